// File: rtl/delay_pkg.sv
// Shared types and helpers for the delay value generator.
// The stats counter widths apply only when DELAY_GEN_STATS_EN is defined.
package delay_pkg;

    typedef enum logic [1:0] {
        CALC = 2'd0,
        DRAW = 2'd1,
        OUT  = 2'd2
    } state_e;

    localparam int unsigned PRBS_W      = 31;
    localparam int unsigned STAT_DRAW_W = 32;
    localparam int unsigned STAT_REJ_W  = 32;
    localparam int unsigned STAT_FB_W   = 16;

    // Smear the highest set bit downwards. The result is the smallest 2^k-1 that is >= r.
    function automatic logic [PRBS_W-1:0] range_to_mask(input logic [PRBS_W-1:0] r);
        logic [PRBS_W-1:0] m;
        m = r;
        for (int unsigned i = 1; i < PRBS_W; i++) begin
            m = m | (r >> i);
        end
        return m;
    endfunction

endpackage

// File: rtl/delay_range_mask.sv
// Combinational range-to-mask encoder: mask_o is the smallest 2^k-1 covering range_i.
module delay_range_mask
    import delay_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] range_i,
    output logic [W-1:0] mask_o
);

    always_comb begin
        mask_o = W'(range_to_mask(PRBS_W'(range_i)));
    end

endmodule

// File: rtl/delay_value_gen.sv
// Turns PRBS words into uniform delay values in [cfg_min, cfg_max] using masked rejection sampling.
// Optional DELAY_GEN_STATS_EN adds saturating draw, reject and fallback counters with a stat_clr input.
module delay_value_gen
    import delay_pkg::*;
#(
    parameter int unsigned DELAY_W    = 16,
    parameter int unsigned MAX_REJECT = 8,
    parameter int unsigned DEF_MIN    = 0,
    parameter int unsigned DEF_MAX    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PRBS_W-1:0]  prbs_do,
    output logic               prbs_advance,
    input  logic [DELAY_W-1:0] cfg_min,
    input  logic [DELAY_W-1:0] cfg_max,
    input  logic               cfg_load,
    output logic               cfg_err,
    output logic [DELAY_W-1:0] delay_val,
    output logic               delay_valid,
    input  logic               delay_ready
`ifdef DELAY_GEN_STATS_EN
    ,
    input  logic                   stat_clr,
    output logic [STAT_DRAW_W-1:0] stat_draws,
    output logic [STAT_REJ_W-1:0]  stat_rejects,
    output logic [STAT_FB_W-1:0]   stat_fallbacks
`endif
);

    localparam logic [7:0] REJ_LAST = 8'(MAX_REJECT - 1);

    state_e             state_q, state_d;
    logic [DELAY_W-1:0] lat_min_q, lat_min_d;
    logic [DELAY_W-1:0] lat_max_q, lat_max_d;
    logic [DELAY_W-1:0] range_q, range_d;
    logic [DELAY_W-1:0] mask_q, mask_d;
    logic               cfg_err_q, cfg_err_d;
    logic [7:0]         rej_cnt_q, rej_cnt_d;
    logic               pend_cfg_q, pend_cfg_d;
    logic [DELAY_W-1:0] delay_val_q, delay_val_d;
    logic               delay_valid_q, delay_valid_d;

    logic               inverted;
    logic [DELAY_W-1:0] range_calc;
    logic [DELAY_W-1:0] mask_calc;
    logic [DELAY_W-1:0] cand;
    logic               accept;
    logic               last_try;
    logic               draw_fire;
    logic               rej_fire;
    logic               fb_fire;

    if (DELAY_W < PRBS_W) begin : g_prbs_hi
        logic prbs_hi_unused;
        always_comb prbs_hi_unused = ^prbs_do[PRBS_W-1:DELAY_W];
    end

    always_comb begin
        inverted   = lat_max_q < lat_min_q;
        range_calc = inverted ? '0 : (lat_max_q - lat_min_q);
        cand       = prbs_do[DELAY_W-1:0] & mask_q;
        accept     = cand <= range_q;
        last_try   = rej_cnt_q == REJ_LAST;
        draw_fire  = state_q == DRAW;
        rej_fire   = draw_fire && !cfg_load && !accept && !last_try;
        fb_fire    = draw_fire && !cfg_load && !accept && last_try;
    end

    delay_range_mask #(.W(DELAY_W)) u_range_mask (
        .range_i (range_calc),
        .mask_o  (mask_calc)
    );

    always_comb begin
        state_d       = state_q;
        lat_min_d     = lat_min_q;
        lat_max_d     = lat_max_q;
        range_d       = range_q;
        mask_d        = mask_q;
        cfg_err_d     = cfg_err_q;
        rej_cnt_d     = rej_cnt_q;
        pend_cfg_d    = pend_cfg_q;
        delay_val_d   = delay_val_q;
        delay_valid_d = delay_valid_q;

        if (cfg_load) begin
            lat_min_d = cfg_min;
            lat_max_d = cfg_max;
        end

        case (state_q)
            CALC: begin
                range_d   = range_calc;
                mask_d    = mask_calc;
                cfg_err_d = inverted;
                rej_cnt_d = '0;
                state_d   = cfg_load ? CALC : DRAW;
            end
            DRAW: begin
                if (cfg_load) begin
                    rej_cnt_d = '0;
                    state_d   = CALC;
                end else if (accept || last_try) begin
                    // Fallback halves the masked draw, which is always below the range.
                    delay_val_d   = lat_min_q + (accept ? cand : (cand >> 1));
                    delay_valid_d = 1'b1;
                    rej_cnt_d     = '0;
                    state_d       = OUT;
                end else begin
                    rej_cnt_d = rej_cnt_q + 8'd1;
                end
            end
            OUT: begin
                if (cfg_load) begin
                    pend_cfg_d = 1'b1;
                end
                if (delay_valid_q && delay_ready) begin
                    delay_valid_d = 1'b0;
                    pend_cfg_d    = 1'b0;
                    state_d       = (pend_cfg_q || cfg_load) ? CALC : DRAW;
                end
            end
            default: state_d = CALC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= CALC;
            lat_min_q     <= DELAY_W'(DEF_MIN);
            lat_max_q     <= DELAY_W'(DEF_MAX);
            range_q       <= '0;
            mask_q        <= '0;
            cfg_err_q     <= 1'b0;
            rej_cnt_q     <= '0;
            pend_cfg_q    <= 1'b0;
            delay_val_q   <= '0;
            delay_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lat_min_q     <= lat_min_d;
            lat_max_q     <= lat_max_d;
            range_q       <= range_d;
            mask_q        <= mask_d;
            cfg_err_q     <= cfg_err_d;
            rej_cnt_q     <= rej_cnt_d;
            pend_cfg_q    <= pend_cfg_d;
            delay_val_q   <= delay_val_d;
            delay_valid_q <= delay_valid_d;
        end
    end

    always_comb begin
        prbs_advance = draw_fire;
        cfg_err      = cfg_err_q;
        delay_val    = delay_val_q;
        delay_valid  = delay_valid_q;
    end

`ifdef DELAY_GEN_STATS_EN
    logic [STAT_DRAW_W-1:0] stat_draws_q, stat_draws_d;
    logic [STAT_REJ_W-1:0]  stat_rejects_q, stat_rejects_d;
    logic [STAT_FB_W-1:0]   stat_fallbacks_q, stat_fallbacks_d;

    always_comb begin
        stat_draws_d     = stat_draws_q;
        stat_rejects_d   = stat_rejects_q;
        stat_fallbacks_d = stat_fallbacks_q;
        if (stat_clr) begin
            stat_draws_d     = '0;
            stat_rejects_d   = '0;
            stat_fallbacks_d = '0;
        end else begin
            if (draw_fire && stat_draws_q != '1)     stat_draws_d     = stat_draws_q + 1'b1;
            if (rej_fire && stat_rejects_q != '1)    stat_rejects_d   = stat_rejects_q + 1'b1;
            if (fb_fire && stat_fallbacks_q != '1)   stat_fallbacks_d = stat_fallbacks_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_draws_q     <= '0;
            stat_rejects_q   <= '0;
            stat_fallbacks_q <= '0;
        end else begin
            stat_draws_q     <= stat_draws_d;
            stat_rejects_q   <= stat_rejects_d;
            stat_fallbacks_q <= stat_fallbacks_d;
        end
    end

    always_comb begin
        stat_draws     = stat_draws_q;
        stat_rejects   = stat_rejects_q;
        stat_fallbacks = stat_fallbacks_q;
    end
`else
    logic stats_unused;
    always_comb stats_unused = rej_fire ^ fb_fire;
`endif

endmodule

// File: tb/tb_delay_value_gen.sv
// Randomized bench for delay_value_gen with a transaction-level rejection-sampling model.
module tb_delay_value_gen;

    localparam int unsigned DW = 16;
    localparam int unsigned MR = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [30:0]   prbs_do;
    logic          prbs_advance;
    logic [DW-1:0] cfg_min;
    logic [DW-1:0] cfg_max;
    logic          cfg_load;
    logic          cfg_err;
    logic [DW-1:0] delay_val;
    logic          delay_valid;
    logic          delay_ready;
    logic          stat_clr;
`ifdef DELAY_GEN_STATS_EN
    logic [31:0]   stat_draws;
    logic [31:0]   stat_rejects;
    logic [15:0]   stat_fallbacks;
`endif

    always #5 clk = ~clk;

    delay_value_gen #(
        .DELAY_W    (DW),
        .MAX_REJECT (MR),
        .DEF_MIN    (0),
        .DEF_MAX    (0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .prbs_do      (prbs_do),
        .prbs_advance (prbs_advance),
        .cfg_min      (cfg_min),
        .cfg_max      (cfg_max),
        .cfg_load     (cfg_load),
        .cfg_err      (cfg_err),
        .delay_val    (delay_val),
        .delay_valid  (delay_valid),
        .delay_ready  (delay_ready)
`ifdef DELAY_GEN_STATS_EN
        ,
        .stat_clr       (stat_clr),
        .stat_draws     (stat_draws),
        .stat_rejects   (stat_rejects),
        .stat_fallbacks (stat_fallbacks)
`endif
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Model state: applied range, pending range, and the value currently owed by the DUT.
    int unsigned m_min, m_max, p_min, p_max;
    bit          m_pend, m_done, m_exp_err;
    int unsigned m_exp, m_rej, idle;
    int unsigned m_draws, m_rejs, m_fbs;
    int unsigned last_acc, acc_cnt, n_adv;
    int unsigned word_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned range_of(input int unsigned lo, input int unsigned hi);
        return (hi < lo) ? 0 : hi - lo;
    endfunction

    function automatic int unsigned mask_of(input int unsigned r);
        int unsigned m = 0;
        while (m < r) m = (m << 1) | 1;
        return m;
    endfunction

    task automatic model_reset();
        m_min = 0; m_max = 0; m_pend = 0; m_done = 0; m_rej = 0; idle = 0;
        m_draws = 0; m_rejs = 0; m_fbs = 0;
    endtask

    task automatic consume(input int unsigned word);
        int unsigned r, cand;
        r    = range_of(m_min, m_max);
        cand = word & mask_of(r);
        if (cand <= r) begin
            m_done = 1; m_exp = m_min + cand;
        end else if (m_rej == MR - 1) begin
            m_done = 1; m_exp = m_min + cand / 2; m_fbs++;
        end else begin
            m_rej++; m_rejs++;
        end
        if (m_done) begin
            m_exp_err = m_max < m_min; m_rej = 0; idle = 0;
        end
    endtask

    // One clock: check outputs against the model, advance the model, then emulate the PRBS step.
    task automatic step();
        bit adv;
        adv = prbs_advance;
        if (rst) begin
            model_reset();
        end else begin
            check_val("valid", delay_valid, m_done);
            if (m_done) begin
                check_val("adv_idle", prbs_advance, 0);
                if (delay_valid) begin
                    check_val("val", delay_val, m_exp);
                    check_val("cfg_err", cfg_err, m_exp_err);
                    if (delay_ready) begin
                        last_acc = delay_val; acc_cnt++;
                        m_done = 0; m_rej = 0; idle = 0;
                        if (m_pend) begin m_min = p_min; m_max = p_max; m_pend = 0; end
                    end
                end
            end
            if (cfg_load) begin
                if (m_done) begin p_min = cfg_min; p_max = cfg_max; m_pend = 1; end
                else begin m_min = cfg_min; m_max = cfg_max; m_rej = 0; idle = 0; end
            end else if (adv && !m_done) begin
                consume(int'(prbs_do[DW-1:0]));
            end
            if (adv) begin m_draws++; n_adv++; end
            if (stat_clr) begin m_draws = 0; m_rejs = 0; m_fbs = 0; end
            if (!m_done) begin
                idle++;
                if (idle > MR + 4) begin
                    check_val("timeout", idle, MR + 4);
                    idle = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        if (adv) prbs_do = (word_q.size() > 0) ? 31'(word_q.pop_front()) : 31'($urandom);
        @(negedge clk);
    endtask

    task automatic restart(input int unsigned lo, input int unsigned hi, input int unsigned first);
        rst = 1; step(); rst = 0;
        word_q.delete();
        prbs_do = 31'(first);
        cfg_min = DW'(lo); cfg_max = DW'(hi); cfg_load = 1;
        step();
        cfg_load = 0;
        n_adv = 0;
    endtask

    task automatic wait_accept(input int unsigned budget);
        int unsigned start = acc_cnt;
        for (int unsigned i = 0; i < budget && acc_cnt == start; i++) step();
        if (acc_cnt == start) check_val("accept_timeout", acc_cnt, start + 1);
    endtask

    task automatic wait_valid(input int unsigned budget);
        for (int unsigned i = 0; i < budget && !delay_valid; i++) step();
        check_val("wait_valid", delay_valid, 1);
    endtask

    initial begin
        logic [DW-1:0] hold;
        rst = 1; cfg_load = 0; cfg_min = '0; cfg_max = '0; delay_ready = 0; stat_clr = 0;
        prbs_do = 31'($urandom);
        acc_cnt = 0; last_acc = 0; n_adv = 0;
        model_reset();
        @(negedge clk);
        step(); step();
        check_val("rst_valid", delay_valid, 0);
        check_val("rst_val", delay_val, 0);
        check_val("rst_err", cfg_err, 0);

        // Fixed range: every value equals the bound.
        restart(100, 100, $urandom);
        delay_ready = 1;
        repeat (20) step();
        check_val("t1_val", last_acc, 100);
        check_val("t1_err", cfg_err, 0);

        // Two rejects then an accept.
        restart(10, 15, ($urandom << 3) | 6);
        word_q.push_back(($urandom << 3) | 7);
        word_q.push_back(($urandom << 3) | 3);
        wait_accept(20);
        check_val("t2_val", last_acc, 13);
        check_val("t2_adv", n_adv, 3);

        // Rejects exhaust the budget and the fallback value is used.
        restart(0, 4, ($urandom << 3) | 7);
        for (int i = 0; i < 3; i++) word_q.push_back(($urandom << 3) | 7);
        wait_accept(20);
        check_val("t3_val", last_acc, 3);
        check_val("t3_adv", n_adv, 4);

        // Inverted bounds collapse the range to the minimum.
        restart(50, 40, $urandom);
        wait_accept(20);
        check_val("t4_val", last_acc, 50);
        check_val("t4_err", cfg_err, 1);
        repeat (10) step();
        check_val("t4_val2", last_acc, 50);

        // Stall in OUT with a load arriving mid-stall.
        delay_ready = 0;
        wait_valid(20);
        hold = delay_val;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin cfg_min = '0; cfg_max = 16'd1; cfg_load = 1; end
            step();
            cfg_load = 0;
            check_val("t5_hold", delay_val, hold);
            check_val("t5_valid", delay_valid, 1);
        end
        delay_ready = 1;
        step();
        check_val("t5_calc_adv", prbs_advance, 0);
        wait_accept(20);
        check_val("t5_range", last_acc <= 1, 1);

        // Reset while a value is held.
        delay_ready = 0;
        wait_valid(20);
        rst = 1; step(); rst = 0;
        check_val("t6_valid0", delay_valid, 0);
        check_val("t6_val0", delay_val, 0);
        step();
        check_val("t6_valid1", delay_valid, 0);
        step();
        check_val("t6_valid2", delay_valid, 1);
        check_val("t6_val2", delay_val, 0);

        // Random traffic with random loads, stalls and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            delay_ready = $urandom_range(0, 3) != 0;
            rst = $urandom_range(0, 499) == 0;
            if (!rst && $urandom_range(0, 39) == 0) begin
                cfg_min = DW'($urandom_range(0, 300));
                cfg_max = ($urandom_range(0, 3) == 0) ? DW'($urandom) : cfg_min + DW'($urandom_range(0, 40));
                cfg_load = 1;
            end
            step();
            cfg_load = 0; rst = 0;
        end

`ifdef DELAY_GEN_STATS_EN
        check_val("stat_draws", stat_draws, m_draws);
        check_val("stat_rejects", stat_rejects, m_rejs);
        check_val("stat_fallbacks", stat_fallbacks, m_fbs);
        stat_clr = 1; step(); stat_clr = 0;
        check_val("stat_clr", stat_draws, m_draws);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
